// File: rtl/ddr4_app_pkg.sv
// Shared constants and width helpers for the DDR4 app arbiter.
// Latency: none (package only).
// Backpressure: not applicable.
package ddr4_app_pkg;

  localparam int APP_CMD_WRITE = 0;
  localparam int APP_CMD_READ  = 1;

  // Width of a port index; a single port still needs a 1-bit tag.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a credit counter able to hold 0..depth inclusive.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ddr4_app_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one DDR4 app port and routes read returns back by tag.
// Latency: grant to ddr4_app_en_o 1 cycle; DDR return to port valid 1 cycle.
// Backpressure: slot holds until app/wdf ready; reads need a credit; returns wait on the owning port's ready.
module ddr4_app_arbiter
  import ddr4_app_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 28,
  parameter int CMD_W     = 3,
  parameter int DATA_W    = 512,
  parameter int RD_DEPTH  = 16,
  parameter int ARB_MODE  = 0
) (
  input  logic                          ddr4_ui_clk_i,
  input  logic                          ddr4_ui_rstn_i,
  input  logic [NUM_PORTS-1:0]          port_app_en_i,
  input  logic [NUM_PORTS*CMD_W-1:0]    port_app_cmd_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_app_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_app_wdf_data_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0] port_app_wdf_mask_i,
  output logic [NUM_PORTS-1:0]          port_app_rdy_o,
  output logic [DATA_W-1:0]             port_app_rd_data_o,
  output logic [NUM_PORTS-1:0]          port_app_rd_data_valid_o,
  input  logic [NUM_PORTS-1:0]          port_app_rd_data_rdy_i,
  output logic [ADDR_W-1:0]             ddr4_app_addr_o,
  output logic [CMD_W-1:0]              ddr4_app_cmd_o,
  output logic                          ddr4_app_en_o,
  output logic [DATA_W-1:0]             ddr4_app_wdf_data_o,
  output logic                          ddr4_app_wdf_end_o,
  output logic [DATA_W/8-1:0]           ddr4_app_wdf_mask_o,
  output logic                          ddr4_app_wdf_wren_o,
  input  logic                          ddr4_app_rdy_i,
  input  logic                          ddr4_app_wdf_rdy_i,
  input  logic [DATA_W-1:0]             ddr4_app_rd_data_i,
  input  logic                          ddr4_app_rd_data_end_i,
  input  logic                          ddr4_app_rd_data_valid_i,
  output logic                          err_o
);

  localparam int IDX_W  = idx_w(NUM_PORTS);
  localparam int CRED_W = cred_w(RD_DEPTH);
  localparam int MASK_W = DATA_W / 8;

  logic clk;
  logic rst_n;
  assign clk   = ddr4_ui_clk_i;
  assign rst_n = ddr4_ui_rstn_i;

  logic                 slot_vld, slot_rd;
  logic [IDX_W-1:0]     slot_port;
  logic [CMD_W-1:0]     slot_cmd;
  logic [ADDR_W-1:0]    slot_addr;
  logic [DATA_W-1:0]    slot_data;
  logic [MASK_W-1:0]    slot_mask;
  logic                 slot_fire, can_grant;
  logic [NUM_PORTS-1:0] elig;
  logic                 found, grant_vld, grant_rd, bad_cmd;
  logic [IDX_W-1:0]     grant_idx, rr_ptr;
  logic [CMD_W-1:0]     sel_cmd;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic [MASK_W-1:0]    sel_mask;
  logic [CRED_W-1:0]    credits;
  logic                 cred_dec;
  logic                 tag_push, tag_full, tag_empty;
  logic [IDX_W-1:0]     tag_head;
  logic                 ret_beat, ret_push, ret_pop, ret_full, ret_empty, orphan;
  logic [IDX_W-1:0]     ret_tag;
  logic [IDX_W+DATA_W-1:0] ret_head;

  assign slot_fire = slot_vld && ddr4_app_rdy_i && (slot_rd || ddr4_app_wdf_rdy_i);
  assign can_grant = !slot_vld || slot_fire;

  // A read needs a credit to be eligible; writes never wait on credits.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig[p] = port_app_en_i[p] &&
                ((port_app_cmd_i[p*CMD_W +: CMD_W] == CMD_W'(APP_CMD_WRITE)) || (credits != '0));
    end
  end

  // Pick the first eligible port, scanning from the RR pointer or from port 0.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sel_cmd   = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_mask  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int p;
      p = (ARB_MODE == 1) ? i : int'(rr_ptr) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && elig[p]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(p);
        sel_cmd   = port_app_cmd_i[p*CMD_W +: CMD_W];
        sel_addr  = port_app_addr_i[p*ADDR_W +: ADDR_W];
        sel_data  = port_app_wdf_data_i[p*DATA_W +: DATA_W];
        sel_mask  = port_app_wdf_mask_i[p*MASK_W +: MASK_W];
      end
    end
  end

  assign grant_vld      = found && can_grant && rst_n;
  assign grant_rd       = (sel_cmd != CMD_W'(APP_CMD_WRITE));
  assign bad_cmd        = grant_rd && (sel_cmd != CMD_W'(APP_CMD_READ));
  assign cred_dec       = grant_vld && grant_rd;
  assign port_app_rdy_o = grant_vld ? (NUM_PORTS'(1) << grant_idx) : '0;

  // Slot occupancy: load on grant, empty when the held command fires.
  always_ff @(posedge clk) begin
    if (!rst_n)         slot_vld <= 1'b0;
    else if (grant_vld) slot_vld <= 1'b1;
    else if (slot_fire) slot_vld <= 1'b0;
  end

  // Slot payload; unknown commands are issued to the controller as reads.
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      slot_rd   <= grant_rd;
      slot_port <= grant_idx;
      slot_cmd  <= grant_rd ? CMD_W'(APP_CMD_READ) : CMD_W'(APP_CMD_WRITE);
      slot_addr <= sel_addr;
      slot_data <= sel_data;
      slot_mask <= sel_mask;
    end
  end

  assign ddr4_app_en_o       = slot_vld;
  assign ddr4_app_cmd_o      = slot_cmd;
  assign ddr4_app_addr_o     = slot_addr;
  assign ddr4_app_wdf_data_o = slot_data;
  assign ddr4_app_wdf_mask_o = slot_mask;
  assign ddr4_app_wdf_wren_o = slot_vld && !slot_rd;
  assign ddr4_app_wdf_end_o  = slot_vld && !slot_rd;

  // Round-robin pointer moves past the winner; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n)         rr_ptr <= '0;
    else if (grant_vld) rr_ptr <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Credits track free return-buffer entries across slot, tag FIFO and return FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n)                   credits <= CRED_W'(RD_DEPTH);
    else if (cred_dec && !ret_pop) credits <= credits - CRED_W'(1);
    else if (!cred_dec && ret_pop) credits <= credits + CRED_W'(1);
  end

  assign tag_push = slot_fire && slot_rd;
  assign ret_beat = ddr4_app_rd_data_valid_i && ddr4_app_rd_data_end_i;
  assign ret_push = ret_beat && !tag_empty;
  assign orphan   = ret_beat && tag_empty;

  sync_fifo #(.WIDTH(IDX_W), .DEPTH(RD_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (slot_port),
    .pop       (ret_push),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  sync_fifo #(.WIDTH(IDX_W + DATA_W), .DEPTH(RD_DEPTH)) u_ret_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ret_push),
    .push_data ({tag_head, ddr4_app_rd_data_i}),
    .pop       (ret_pop),
    .pop_data  (ret_head),
    .full      (ret_full),
    .empty     (ret_empty)
  );

  assign ret_tag                  = ret_head[IDX_W+DATA_W-1:DATA_W];
  assign port_app_rd_data_o       = ret_head[DATA_W-1:0];
  assign port_app_rd_data_valid_o = ret_empty ? '0 : (NUM_PORTS'(1) << ret_tag);
  assign ret_pop                  = !ret_empty && port_app_rd_data_rdy_i[ret_tag];

  // Sticky error: orphan return, unknown command, or a FIFO push while full.
  always_ff @(posedge clk) begin
    if (!rst_n) err_o <= 1'b0;
    else if (orphan || (grant_vld && bad_cmd) || (tag_push && tag_full) || (ret_push && ret_full))
      err_o <= 1'b1;
  end

endmodule
